// File: rtl/menu_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : menu_ctl_pkg
// Brief    : Shared game screen codes and default frame constants.
// Revision : 1.0 - initial release
// ============================================================================
package menu_ctl_pkg;

    // Screen codes shared with the menu background and overlay blocks
    typedef enum logic [1:0] {
        ST_MENU      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_RESULT    = 2'd3
    } game_state_t;

    localparam int OPT_START         = 0;
    localparam int DEF_LIGHT_FRAMES  = 60;
    localparam int DEF_RESULT_FRAMES = 300;
    localparam int N_LIGHTS          = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/menu_ctl_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Brief    : Per-bit rising-edge detector; rise is high while din is high and
//            was low on the previous clock.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= din;
        end
    end

    assign rise = din & ~r_q;

endmodule
`default_nettype wire

// File: rtl/menu_ctl.sv
`default_nettype none
// ============================================================================
// Module   : menu_ctl
// Brief    : Screen sequencer MENU -> COUNTDOWN -> RACE -> RESULT driven by
//            key presses and frame ticks derived from vsync.
// Revision : 1.0 - initial release
// ============================================================================
module menu_ctl
    import menu_ctl_pkg::*;
#(
    parameter int N_OPTIONS     = 3,
    parameter int LIGHT_FRAMES  = DEF_LIGHT_FRAMES,
    parameter int RESULT_FRAMES = DEF_RESULT_FRAMES,
    parameter int SEL_W         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync_in,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_enter,
    input  logic             key_esc,
    input  logic             race_finished,
    output logic [1:0]       state,
    output logic [SEL_W-1:0] menu_sel,
    output logic             opt_pulse,
    output logic [SEL_W-1:0] opt_idx,
    output logic [1:0]       lights,
    output logic             menu_en,
    output logic             race_en
);

    localparam int CNT_MAX = max_int(LIGHT_FRAMES, RESULT_FRAMES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] c_light_last  = CNT_W'(LIGHT_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_result_last = CNT_W'(RESULT_FRAMES - 1);
    localparam logic [SEL_W-1:0] c_sel_last    = SEL_W'(N_OPTIONS - 1);
    localparam logic [SEL_W-1:0] c_sel_start   = SEL_W'(OPT_START);

    logic [4:0] w_rise;
    logic       w_tick;
    logic       w_esc;
    logic       w_enter;
    logic       w_down;
    logic       w_up;

    edge_detect #(
        .WIDTH (5)
    ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  ({vsync_in, key_esc, key_enter, key_down, key_up}),
        .rise (w_rise)
    );

    assign {w_tick, w_esc, w_enter, w_down, w_up} = w_rise;

    game_state_t      r_state,     w_state_nxt;
    logic [SEL_W-1:0] r_sel,       w_sel_nxt;
    logic [1:0]       r_lights,    w_lights_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_opt_pulse, w_opt_pulse_nxt;
    logic [SEL_W-1:0] r_opt_idx,   w_opt_idx_nxt;
    logic             r_menu_en;
    logic             r_race_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_MENU;
            r_sel       <= '0;
            r_lights    <= '0;
            r_cnt       <= '0;
            r_opt_pulse <= 1'b0;
            r_opt_idx   <= '0;
            r_menu_en   <= 1'b1;
            r_race_en   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_lights    <= w_lights_nxt;
            r_cnt       <= w_cnt_nxt;
            r_opt_pulse <= w_opt_pulse_nxt;
            r_opt_idx   <= w_opt_idx_nxt;
            r_menu_en   <= (w_state_nxt == ST_MENU);
            r_race_en   <= (w_state_nxt == ST_RACE);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_lights_nxt    = r_lights;
        w_cnt_nxt       = r_cnt;
        w_opt_pulse_nxt = 1'b0;
        w_opt_idx_nxt   = r_opt_idx;

        case (r_state)
            ST_MENU: begin
                // esc has top priority and does nothing here, so it masks the rest
                if (!w_esc) begin
                    if (w_enter) begin
                        if (r_sel == c_sel_start) begin
                            w_state_nxt  = ST_COUNTDOWN;
                            w_lights_nxt = 2'(N_LIGHTS);
                        end else begin
                            w_opt_pulse_nxt = 1'b1;
                            w_opt_idx_nxt   = r_sel;
                        end
                    end else if (w_up && !w_down) begin
                        w_sel_nxt = (r_sel == '0) ? c_sel_last : r_sel - SEL_W'(1);
                    end else if (w_down && !w_up) begin
                        w_sel_nxt = (r_sel == c_sel_last) ? '0 : r_sel + SEL_W'(1);
                    end
                end
            end

            ST_COUNTDOWN: begin
                if (w_esc) begin
                    w_state_nxt  = ST_MENU;
                    w_lights_nxt = '0;
                end else if (w_tick) begin
                    if (r_cnt == c_light_last) begin
                        w_cnt_nxt = '0;
                        if (r_lights == 2'd1) begin
                            w_state_nxt  = ST_RACE;
                            w_lights_nxt = '0;
                        end else begin
                            w_lights_nxt = r_lights - 2'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_RACE: begin
                if (w_esc) begin
                    w_state_nxt = ST_MENU;
                end else if (race_finished) begin
                    w_state_nxt = ST_RESULT;
                end
            end

            ST_RESULT: begin
                if (w_esc || w_enter) begin
                    w_state_nxt = ST_MENU;
                    w_sel_nxt   = '0;
                end else if (w_tick) begin
                    if (r_cnt == c_result_last) begin
                        w_state_nxt = ST_MENU;
                        w_sel_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_MENU;
            end
        endcase

        // Every screen change restarts frame counting from zero
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    assign state     = r_state;
    assign menu_sel  = r_sel;
    assign lights    = r_lights;
    assign opt_pulse = r_opt_pulse;
    assign opt_idx   = r_opt_idx;
    assign menu_en   = r_menu_en;
    assign race_en   = r_race_en;

endmodule
`default_nettype wire

// File: tb/tb_menu_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_ctl
// Brief    : Directed and randomized bench for menu_ctl against a frame-budget
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_ctl;

    localparam int N_OPT = 3;
    localparam int LF    = 2;
    localparam int RF    = 4;
    localparam int SW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          vsync_in, key_up, key_down, key_enter, key_esc, race_finished;
    logic [1:0]    state;
    logic [SW-1:0] menu_sel;
    logic          opt_pulse;
    logic [SW-1:0] opt_idx;
    logic [1:0]    lights;
    logic          menu_en, race_en;

    menu_ctl #(
        .N_OPTIONS     (N_OPT),
        .LIGHT_FRAMES  (LF),
        .RESULT_FRAMES (RF),
        .SEL_W         (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vsync_in      (vsync_in),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_enter     (key_enter),
        .key_esc       (key_esc),
        .race_finished (race_finished),
        .state         (state),
        .menu_sel      (menu_sel),
        .opt_pulse     (opt_pulse),
        .opt_idx       (opt_idx),
        .lights        (lights),
        .menu_en       (menu_en),
        .race_en       (race_en)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: screen, highlighted entry and remaining frame budget
    int m_state, m_sel, m_left, m_pulse, m_idx;
    bit p_up, p_dn, p_en, p_esc, p_vs;

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_left = 0; m_pulse = 0; m_idx = 0;
        p_up = 0; p_dn = 0; p_en = 0; p_esc = 0; p_vs = 0;
    endtask

    task automatic model_step();
        bit pu, pd, pe, px, tk;
        pu = key_up && !p_up;
        pd = key_down && !p_dn;
        pe = key_enter && !p_en;
        px = key_esc && !p_esc;
        tk = vsync_in && !p_vs;
        m_pulse = 0;
        case (m_state)
            0: if (!px) begin
                if (pe) begin
                    if (m_sel == 0) begin
                        m_state = 1;
                        m_left  = 3 * LF;
                    end else begin
                        m_pulse = 1;
                        m_idx   = m_sel;
                    end
                end else if (pu && !pd) begin
                    m_sel = (m_sel + N_OPT - 1) % N_OPT;
                end else if (pd && !pu) begin
                    m_sel = (m_sel + 1) % N_OPT;
                end
            end
            1: if (px) begin
                m_state = 0;
            end else if (tk) begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
            2: if (px) begin
                m_state = 0;
            end else if (race_finished) begin
                m_state = 3;
                m_left  = RF;
            end
            default: if (px || pe) begin
                m_state = 0;
                m_sel   = 0;
            end else if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    m_state = 0;
                    m_sel   = 0;
                end
            end
        endcase
        p_up = key_up; p_dn = key_down; p_en = key_enter; p_esc = key_esc; p_vs = vsync_in;
    endtask

    task automatic check_all();
        int exp_lights;
        exp_lights = (m_state == 1) ? (m_left + LF - 1) / LF : 0;
        chk("state",     32'(state),     32'(m_state));
        chk("menu_sel",  32'(menu_sel),  32'(m_sel));
        chk("lights",    32'(lights),    32'(exp_lights));
        chk("opt_pulse", 32'(opt_pulse), 32'(m_pulse));
        chk("opt_idx",   32'(opt_idx),   32'(m_idx));
        chk("menu_en",   32'(menu_en),   32'(m_state == 0));
        chk("race_en",   32'(race_en),   32'(m_state == 2));
    endtask

    // Called at a falling edge: apply inputs, advance model, check after next rise
    task automatic cycle(input bit u, input bit d, input bit e, input bit x,
                         input bit vs, input bit fin);
        key_up = u; key_down = d; key_enter = e; key_esc = x;
        vsync_in = vs; race_finished = fin;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input bit u, input bit d, input bit e, input bit x);
        cycle(u, d, e, x, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        vsync_in = 0; key_up = 0; key_down = 0; key_enter = 0; key_esc = 0;
        race_finished = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Menu navigation with wrap both ways, and a long hold
        press(1, 0, 0, 0);
        repeat (4) press(0, 1, 0, 0);
        for (int i = 0; i < 1000; i++) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        press(0, 1, 0, 1);
        press(1, 1, 0, 0);
        press(0, 0, 0, 0);

        // Option strobe on a settings entry, then back to START
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        press(0, 0, 1, 0);
        repeat (3) frame();

        // Asynchronous reset between edges while counting down
        #2 rst = 1'b1;
        #1;
        chk("async_state",   32'(state),    32'd0);
        chk("async_lights",  32'(lights),   32'd0);
        chk("async_sel",     32'(menu_sel), 32'd0);
        chk("async_menu_en", 32'(menu_en),  32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();

        // Full countdown, esc mid countdown
        press(0, 0, 1, 0);
        repeat (6) frame();
        press(0, 0, 0, 1);
        press(0, 0, 1, 0);
        repeat (2) frame();
        press(0, 0, 0, 1);

        // Race: esc beats finish; finish alone; result timeout
        press(0, 0, 1, 0);
        repeat (6) frame();
        cycle(0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        press(0, 0, 1, 0);
        repeat (6) frame();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        repeat (4) frame();
        cycle(0, 0, 0, 0, 0, 1);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) == 0) ? ~key_up    : key_up,
                  ($urandom_range(0, 3) == 0) ? ~key_down  : key_down,
                  ($urandom_range(0, 4) == 0) ? ~key_enter : key_enter,
                  ($urandom_range(0, 15) == 0) ? ~key_esc  : key_esc,
                  ($urandom_range(0, 1) == 0) ? ~vsync_in  : vsync_in,
                  ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
